avr_xmem_bridge: RTL

Bridges the AVR external-memory bus (multiplexed AD[7:0], A[15:8], ALE, WR_n, RD_n) into the FPGA's internal peripheral register bus (a[2:0], d[7:0], wdstb, per-slot 8-bit read data). It is the bus initiator for the timer and the other register-mapped peripherals. Each AVR bus cycle is decoded to one slot and one register, and becomes at most one single-clock strobe. All AVR inputs are asynchronous to clk and are synchronised inside the block.

---
 rtl/avrxb_pkg.sv | 26 ++
 rtl/avr_xmem_bridge_sync2.sv | 34 +++
 rtl/avr_xmem_bridge.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/avrxb_pkg.sv
// avrxb_pkg: shared definitions for the AVR external-memory bridge and the
// register-mapped peripherals hanging off it.
//   state_e       bridge FSM states
//   UNMAPPED_DEF  read value for addresses outside every slot
//   REG_*         register offsets (0..7) common to all peripherals
package avrxb_pkg;

    typedef enum logic [1:0] {
        S_QUIET = 2'd0,
        S_IDLE  = 2'd1,
        S_WR    = 2'd2,
        S_RD    = 2'd3
    } state_e;

    localparam logic [7:0] UNMAPPED_DEF = 8'h5a;

    localparam logic [2:0] REG_CNTRL = 3'd0;
    localparam logic [2:0] REG_CNTRH = 3'd1;
    localparam logic [2:0] REG_CMPL  = 3'd2;
    localparam logic [2:0] REG_CMPH  = 3'd3;
    localparam logic [2:0] REG_PRSC  = 3'd4;
    localparam logic [2:0] REG_STAT  = 3'd5;
    localparam logic [2:0] REG_IEN   = 3'd6;
    localparam logic [2:0] REG_CTRL  = 3'd7;

endpackage

// File: rtl/avr_xmem_bridge_sync2.sv
// sync2: two-flop synchroniser for an asynchronous single-bit input.
// Both stages are exported because the bridge samples data on s1 while it
// detects edges on s2.
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset (flops load RST_VAL)
//   d_i      in   asynchronous input
//   s1_o     out  first stage
//   s2_o     out  second stage
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic s1_o,
    output logic s2_o
);

    logic s1_q, s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign s1_o = s1_q;
    assign s2_o = s2_q;

endmodule

// File: rtl/avr_xmem_bridge.sv
// avr_xmem_bridge: AVR multiplexed external-memory bus to internal peripheral
// register bus. Each AVR cycle becomes at most one single-clock strobe.
// Optional feature macro: AVRXB_IRQ_EN (interrupt pending/mask registers just
// above the slot range, and an active-low irq_n output).
//   clk, reset_n          system clock, async active-low reset
//   ale, wr_n, rd_n       AVR strobes (asynchronous)
//   ad_in, ah             AVR AD[7:0] input side, A[15:8]
//   ad_out, ad_oe         AVR AD drive value and output enable
//   a, d, cs              peripheral register address, write data, slot select
//   wdstb, rdstb          one-clock write / read strobes
//   rdata                 flat per-slot read data, slot i at [8i+7:8i]
//   irq_in, irq_n         peripheral interrupts in, AVR interrupt pin out
module avr_xmem_bridge
    import avrxb_pkg::*;
#(
    parameter int          NSLOT     = 4,
    parameter logic [15:0] BASE_ADDR = 16'h1100,
    parameter logic [7:0]  UNMAPPED  = UNMAPPED_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ale,
    input  logic               wr_n,
    input  logic               rd_n,
    input  logic [7:0]         ad_in,
    input  logic [7:0]         ah,
    output logic [7:0]         ad_out,
    output logic               ad_oe,
    output logic [2:0]         a,
    output logic [7:0]         d,
    output logic [NSLOT-1:0]   cs,
    output logic               wdstb,
    output logic               rdstb,
    input  logic [8*NSLOT-1:0] rdata,
    input  logic [NSLOT-1:0]   irq_in,
    output logic               irq_n
);

    localparam int          SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [15:0] SPAN   = 16'(8 * NSLOT);

    // ---------------- synchronisers ----------------
    logic ale_s1, ale_s2, wr_s1, wr_s2, rd_s1_unused, rd_s2;

    sync2 #(.RST_VAL(1'b0)) u_sync_ale (.clk(clk), .reset_n(reset_n), .d_i(ale),
                                        .s1_o(ale_s1), .s2_o(ale_s2));
    sync2 #(.RST_VAL(1'b1)) u_sync_wr  (.clk(clk), .reset_n(reset_n), .d_i(wr_n),
                                        .s1_o(wr_s1), .s2_o(wr_s2));
    sync2 #(.RST_VAL(1'b1)) u_sync_rd  (.clk(clk), .reset_n(reset_n), .d_i(rd_n),
                                        .s1_o(rd_s1_unused), .s2_o(rd_s2));

    logic ale_prev_q, wr_prev_q, rd_prev_q;
    logic ale_fall, wr_fall, wr_rise, rd_fall, rd_rise;

    assign ale_fall = ale_prev_q & ~ale_s2;
    assign wr_fall  = wr_prev_q  & ~wr_s2;
    assign wr_rise  = ~wr_prev_q &  wr_s2;
    assign rd_fall  = rd_prev_q  & ~rd_s2;
    assign rd_rise  = ~rd_prev_q &  rd_s2;

    // ---------------- address / data capture ----------------
    logic [7:0] alo_q, ah_q, wdat_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alo_q      <= '0;
            ah_q       <= '0;
            wdat_q     <= '0;
            ale_prev_q <= 1'b0;
        end else begin
            ale_prev_q <= ale_s2;
            if (ale_s1)
                alo_q <= ad_in;
            if (ale_fall)
                ah_q <= ah;
            if (!wr_s1 && !ale_s1)
                wdat_q <= ad_in;
        end
    end

    // ---------------- decode ----------------
`ifdef AVRXB_IRQ_EN
    logic [NSLOT-1:0] mask_q;
    logic             is_pend, is_mask;
`endif
    logic [15:0]       addr, off;
    logic              mapped;
    logic [SLOT_W-1:0] slot;
    logic [NSLOT-1:0]  slot_oh;
    logic [7:0]        rd_val;

    always_comb begin
        addr    = {ah_q, alo_q};
        off     = addr - BASE_ADDR;   // wraps below BASE_ADDR, so one compare covers both ends
        mapped  = (off < SPAN);
        slot    = off[SLOT_W+2:3];
        slot_oh = NSLOT'(1) << slot;
        rd_val  = UNMAPPED;
`ifdef AVRXB_IRQ_EN
        is_pend = (off == SPAN);
        is_mask = (off == SPAN + 16'd1);
        if (mapped)
            rd_val = rdata[{slot, 3'b000} +: 8];
        else if (is_pend)
            rd_val = 8'(irq_in);
        else if (is_mask)
            rd_val = 8'(mask_q);
`else
        if (mapped)
            rd_val = rdata[{slot, 3'b000} +: 8];
`endif
    end

    // ---------------- bus FSM ----------------
    state_e           state_q;
    logic             quiet_q;
    logic [1:0]       fill_q;
    logic             oe_q;
    logic [7:0]       ad_out_q, d_q;
    logic [2:0]       a_q;
    logic [NSLOT-1:0] cs_q;
    logic             wdstb_q, rdstb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_QUIET;
            quiet_q   <= 1'b0;
            fill_q    <= 2'b00;
            wr_prev_q <= 1'b1;
            rd_prev_q <= 1'b1;
            oe_q      <= 1'b0;
            ad_out_q  <= '0;
            a_q       <= '0;
            d_q       <= '0;
            cs_q      <= '0;
            wdstb_q   <= 1'b0;
            rdstb_q   <= 1'b0;
`ifdef AVRXB_IRQ_EN
            mask_q    <= '1;
`endif
        end else begin
            // fill_q[1] marks the point where s2 reflects the pin rather than
            // the synchroniser reset value; a strobe held low through reset
            // must not look like two idle clocks.
            fill_q    <= {fill_q[0], 1'b1};
            wr_prev_q <= wr_s2;
            rd_prev_q <= rd_s2;
            wdstb_q   <= 1'b0;
            rdstb_q   <= 1'b0;
            case (state_q)
                S_QUIET: begin
                    if (fill_q[1] && wr_s2 && rd_s2) begin
                        if (quiet_q) begin
                            state_q <= S_IDLE;
                            quiet_q <= 1'b0;
                        end else begin
                            quiet_q <= 1'b1;
                        end
                    end else begin
                        quiet_q <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (wr_fall && rd_s2) begin
                        state_q <= S_WR;
                    end else if (rd_fall && wr_s2) begin
                        // ad_out only loads here, while oe is still clear
                        state_q  <= S_RD;
                        oe_q     <= 1'b1;
                        ad_out_q <= rd_val;
                        if (mapped) begin
                            rdstb_q <= 1'b1;
                            a_q     <= addr[2:0];
                            cs_q    <= slot_oh;
                        end else begin
                            // no slot owns this read, so nothing is selected
                            cs_q <= '0;
                        end
                    end else if (!wr_s2 || !rd_s2) begin
                        // simultaneous falls, or a strobe already low
                        state_q <= S_QUIET;
                    end
                end
                S_WR: begin
                    if (wr_rise) begin
                        state_q <= S_IDLE;
                        if (mapped) begin
                            wdstb_q <= 1'b1;
                            a_q     <= addr[2:0];
                            d_q     <= wdat_q;
                            cs_q    <= slot_oh;
                        end
`ifdef AVRXB_IRQ_EN
                        else if (is_mask) begin
                            mask_q <= wdat_q[NSLOT-1:0];
                        end
`endif
                    end
                end
                S_RD: begin
                    if (rd_rise) begin
                        oe_q    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_QUIET;
            endcase
        end
    end

    // raw rd_n releases the bus without waiting for the synchroniser
    assign ad_oe  = oe_q & ~rd_n;
    assign ad_out = ad_out_q;
    assign a      = a_q;
    assign d      = d_q;
    assign cs     = cs_q;
    assign wdstb  = wdstb_q;
    assign rdstb  = rdstb_q;

    // ---------------- interrupt ----------------
`ifdef AVRXB_IRQ_EN
    logic irq_n_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq_n_q <= 1'b1;
        else
            irq_n_q <= ~|(irq_in & mask_q);
    end

    assign irq_n = irq_n_q;
`else
    logic irq_unused;
    assign irq_unused = ^irq_in;
    assign irq_n      = 1'b1;
`endif

endmodule
